// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// mispredict/redirect generation for the flush path, and saturating perf counters.
module btb_entry #(
    parameter int WORD_SIZE = 16,
    parameter int TAG_BITS  = 12,
    parameter int CNT_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 upd,
    input  logic                 hit,
    input  logic                 taken,
    input  logic [TAG_BITS-1:0]  rtag,
    input  logic [WORD_SIZE-1:0] rtarget,
    output logic                 valid,
    output logic [TAG_BITS-1:0]  tag,
    output logic [WORD_SIZE-1:0] target,
    output logic [CNT_BITS-1:0]  cnt
);
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            cnt    <= CNT_WNT;
        end else if (flush) begin
            // Flush beats a same-cycle resolve: nothing gets allocated.
            valid <= 1'b0;
        end else if (upd) begin
            if (hit) begin
                if (taken) begin
                    target <= rtarget;
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_BITS'(1);
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_BITS'(1);
                end
            end else if (taken) begin
                valid  <= 1'b1;
                tag    <= rtag;
                target <= rtarget;
                cnt    <= CNT_WT;
            end
        end
    end
endmodule

module btb_branch_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int MODE      = 2,
    parameter int PERF_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    output logic                 pred_taken,
    input  logic                 resolve_valid,
    input  logic [WORD_SIZE-1:0] resolve_pc,
    input  logic                 resolve_taken,
    input  logic [WORD_SIZE-1:0] resolve_target,
    input  logic [WORD_SIZE-1:0] resolve_pred_next,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 flush_table,
    output logic [PERF_BITS-1:0] pred_count,
    output logic [PERF_BITS-1:0] mispred_count
);
    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

    logic [ENTRIES-1:0]                valid_q;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q;
    logic [ENTRIES-1:0][WORD_SIZE-1:0] target_q;
    logic [ENTRIES-1:0][CNT_BITS-1:0]  cnt_q;
    logic [ENTRIES-1:0]                upd_sel;

    logic [IDX_BITS-1:0] idx, ridx;
    logic [TAG_BITS-1:0] tag, rtag;
    logic                hit, rhit;
    logic [WORD_SIZE-1:0] actual_next;

    assign idx  = pc[IDX_BITS-1:0];
    assign tag  = pc[WORD_SIZE-1:IDX_BITS];
    assign ridx = resolve_pc[IDX_BITS-1:0];
    assign rtag = resolve_pc[WORD_SIZE-1:IDX_BITS];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign rhit = valid_q[ridx] && (tag_q[ridx] == rtag);

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        assign upd_sel[e] = resolve_valid && (ridx == IDX_BITS'(e));
        btb_entry #(.WORD_SIZE(WORD_SIZE), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush_table),
            .upd     (upd_sel[e]),
            .hit     (rhit),
            .taken   (resolve_taken),
            .rtag    (rtag),
            .rtarget (resolve_target),
            .valid   (valid_q[e]),
            .tag     (tag_q[e]),
            .target  (target_q[e]),
            .cnt     (cnt_q[e])
        );
    end

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_taken = 1'b0;
        case (MODE)
            1:       pred_taken = hit;
            2:       pred_taken = hit && cnt_q[idx][CNT_BITS-1];
            default: pred_taken = 1'b0;
        endcase
    end

    assign pred_next_pc = pred_taken ? target_q[idx] : pc + WORD_SIZE'(1);
    assign actual_next  = resolve_taken ? resolve_target : resolve_pc + WORD_SIZE'(1);
    assign redirect_pc  = actual_next;
    assign mispredict   = resolve_valid && (actual_next != resolve_pred_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_count    <= '0;
            mispred_count <= '0;
        end else begin
            if (resolve_valid && (pred_count != '1)) pred_count <= pred_count + PERF_BITS'(1);
            if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + PERF_BITS'(1);
        end
    end
endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed + randomized bench for btb_branch_predictor against an array-based reference model.
module tb_btb_branch_predictor;
    localparam int W = 16;
    localparam int PB = 4;
    localparam int PMAX = 15;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  pc = '0;
    logic [W-1:0]  pred_next_pc;
    logic          pred_taken;
    logic          resolve_valid = 1'b0;
    logic [W-1:0]  resolve_pc = '0;
    logic          resolve_taken = 1'b0;
    logic [W-1:0]  resolve_target = '0;
    logic [W-1:0]  resolve_pred_next = '0;
    logic          mispredict;
    logic [W-1:0]  redirect_pc;
    logic          flush_table = 1'b0;
    logic [PB-1:0] pred_count;
    logic [PB-1:0] mispred_count;

    int checks = 0;
    int failures = 0;

    btb_branch_predictor #(.WORD_SIZE(W), .IDX_BITS(4), .CNT_BITS(2), .MODE(2), .PERF_BITS(PB)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pred_next_pc(pred_next_pc), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_next(resolve_pred_next),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .flush_table(flush_table),
        .pred_count(pred_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, one slot per index
    bit mv[16];
    int mtag[16], mtgt[16], mcnt[16];
    int mpred, mmis;

    function automatic bit m_taken(int p);
        int i = p % 16;
        return mv[i] && (mtag[i] == p / 16) && (mcnt[i] >= 2);
    endfunction

    function automatic int m_next(int p);
        return m_taken(p) ? mtgt[p % 16] : (p + 1) % 65536;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mcnt[i] = 1;
        end
        mpred = 0; mmis = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check lookup/resolve outputs, clock, update model, check perf.
    task automatic step(input bit rv, input int rpc, input bit rtk, input int rtgt, input int rpn,
                        input bit fl, input int fpc);
        int actual, i;
        bit mis;
        @(negedge clk);
        resolve_valid = rv; resolve_pc = W'(rpc); resolve_taken = rtk;
        resolve_target = W'(rtgt); resolve_pred_next = W'(rpn); flush_table = fl; pc = W'(fpc);
        actual = rtk ? rtgt : (rpc + 1) % 65536;
        mis = rv && (actual != rpn);
        #1;
        chk("pred_taken", 32'(pred_taken), 32'(m_taken(fpc)));
        chk("pred_next_pc", 32'(pred_next_pc), 32'(m_next(fpc)));
        chk("mispredict", 32'(mispredict), 32'(mis));
        if (rv) chk("redirect_pc", 32'(redirect_pc), 32'(actual));
        @(posedge clk);
        if (rv && mpred < PMAX) mpred++;
        if (mis && mmis < PMAX) mmis++;
        if (fl) begin
            for (int k = 0; k < 16; k++) mv[k] = 0;
        end else if (rv) begin
            i = rpc % 16;
            if (mv[i] && mtag[i] == rpc / 16) begin
                if (rtk) begin
                    mtgt[i] = rtgt;
                    if (mcnt[i] < CMAX) mcnt[i]++;
                end else if (mcnt[i] > 0) mcnt[i]--;
            end else if (rtk) begin
                mv[i] = 1; mtag[i] = rpc / 16; mtgt[i] = rtgt; mcnt[i] = 2;
            end
        end
        #1;
        chk("pred_count", 32'(pred_count), 32'(mpred));
        chk("mispred_count", 32'(mispred_count), 32'(mmis));
    endtask

    initial begin
        int rpc, rtgt, rpn, act;
        bit rtk;
        m_reset();
        reset = 1'b1;
        #12 reset = 1'b0;

        // Post-reset state
        pc = 16'h0023;
        #1;
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_next_pc", 32'(pred_next_pc), 32'h0024);
        chk("rst_pred_count", 32'(pred_count), 32'd0);
        chk("rst_mispred_count", 32'(mispred_count), 32'd0);

        // Allocate, then hit
        step(1, 'h23, 1, 'h40, 'h24, 0, 'h23);
        step(0, 0, 0, 0, 0, 0, 'h23);
        chk("alloc_hit_next", 32'(pred_next_pc), 32'h0040);
        // Hysteresis down to and past zero
        step(1, 'h23, 0, 0, 'h40, 0, 'h23);
        step(1, 'h23, 0, 0, 'h24, 0, 'h23);
        chk("hyst_next", 32'(pred_next_pc), 32'h0024);
        step(1, 'h23, 0, 0, 'h24, 0, 'h23);
        step(1, 'h23, 1, 'h40, 'h24, 0, 'h23);
        chk("sat0_still_nt", 32'(pred_taken), 32'd0);
        // Alias replacement on index 3
        step(1, 'h13, 1, 'h80, 'h14, 0, 'h23);
        step(0, 0, 0, 0, 0, 0, 'h23);
        step(0, 0, 0, 0, 0, 0, 'h13);
        chk("alias_next", 32'(pred_next_pc), 32'h0080);
        // Flush beats a same-cycle allocation
        step(1, 'h55, 1, 'h99, 'h56, 1, 'h13);
        step(0, 0, 0, 0, 0, 0, 'h55);
        step(0, 0, 0, 0, 0, 0, 'h13);
        // PC wrap on lookup and on redirect
        step(1, 'hFFFF, 0, 0, 'h1, 0, 'hFFFF);
        chk("wrap_next", 32'(pred_next_pc), 32'h0000);
        // Mispredict burst saturating the 4-bit counters
        for (int n = 0; n < 20; n++) begin
            rpc = $urandom_range(0, 65535); rtk = 1'($urandom); rtgt = $urandom_range(0, 65535);
            act = rtk ? rtgt : (rpc + 1) % 65536;
            step(1, rpc, rtk, rtgt, (act + 1) % 65536, 0, $urandom_range(0, 65535));
        end
        chk("sat_mispred", 32'(mispred_count), 32'd15);

        // Asynchronous reset in the middle of a resolving cycle
        @(negedge clk);
        resolve_valid = 1'b1; resolve_pc = 16'h0033; resolve_taken = 1'b1;
        resolve_target = 16'h0777; resolve_pred_next = 16'h0034; pc = 16'h0013;
        #2 reset = 1'b1;
        #1;
        chk("midrst_pred_count", 32'(pred_count), 32'd0);
        chk("midrst_mispred_count", 32'(mispred_count), 32'd0);
        chk("midrst_next_pc", 32'(pred_next_pc), 32'h0014);
        chk("midrst_mispredict", 32'(mispredict), 32'd1);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        resolve_valid = 1'b0;

        // Randomized traffic over a small PC pool for frequent hits and aliases
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) rpc = $urandom_range(0, 65535);
            rtk = 1'($urandom);
            rtgt = $urandom_range(0, 65535);
            rpn = ($urandom_range(0, 1) == 0) ? m_next(rpc) : $urandom_range(0, 65535);
            step(1'($urandom_range(0, 3) != 0), rpc, rtk, rtgt, rpn,
                 $urandom_range(0, 49) == 0, ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
